// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: ICache (m0) and LSU (m1) share one slave
// read port, one burst in flight, round-robin on contention.
module axi_rd_arbiter #(
    parameter int ID_W = 4,
    parameter int AR_W = 45 + ID_W,
    parameter int R_W  = 35 + ID_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    input  logic [AR_W-1:0] m0_ar,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    output logic [R_W-1:0]  m0_r,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    input  logic [AR_W-1:0] m1_ar,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    output logic [R_W-1:0]  m1_r,
    output logic            s_arvalid,
    input  logic            s_arready,
    output logic [AR_W-1:0] s_ar,
    input  logic            s_rvalid,
    output logic            s_rready,
    input  logic [R_W-1:0]  s_r,
    output logic            err_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [7:0]  beats_q, beats_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        err_q, err_d;

    logic [AR_W-1:0] ar_sel;
    logic            rready_sel;
    logic            rlast;

    assign ar_sel     = grant_q ? m1_ar : m0_ar;
    assign rready_sel = grant_q ? m1_rready : m0_rready;
    assign rlast      = s_r[ID_W];
    assign err_len    = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            beats_q <= 8'd0;
            arlen_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            arlen_q <= arlen_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beats_d    = beats_q;
        arlen_d    = arlen_q;
        err_d      = err_q;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_r       = '0;
        m1_r       = '0;
        s_arvalid  = 1'b0;
        s_ar       = '0;
        s_rready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_arvalid && m1_arvalid) begin
                    grant_d = ~last_q;
                    state_d = AR;
                end else if (m0_arvalid) begin
                    grant_d = 1'b0;
                    state_d = AR;
                end else if (m1_arvalid) begin
                    grant_d = 1'b1;
                    state_d = AR;
                end
            end
            AR: begin
                s_arvalid  = 1'b1;
                s_ar       = ar_sel;
                m0_arready = !grant_q && s_arready;
                m1_arready = grant_q && s_arready;
                if (s_arready) begin
                    beats_d = 8'd0;
                    // arlen sits above arsize/arburst in the packed AR word
                    arlen_d = ar_sel[12:5];
                    state_d = R;
                end
            end
            R: begin
                s_rready = rready_sel;
                if (grant_q) begin
                    m1_rvalid = s_rvalid;
                    m1_r      = s_r;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_r      = s_r;
                end
                if (s_rvalid && rready_sel) begin
                    beats_d = beats_q + 8'd1;
                    if (rlast) begin
                        if (beats_q != arlen_q) begin
                            err_d = 1'b1;
                        end
                        last_d  = grant_q;
                        state_d = IDLE;
                    end else if (beats_q == arlen_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a cycle table for basic
// handshakes plus hand-written multi-cycle bursts.
module tb_axi_rd_arbiter;

    localparam int ID_W = 4;
    localparam int AR_W = 45 + ID_W;
    localparam int R_W  = 35 + ID_W;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic            m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [AR_W-1:0] m0_ar, m1_ar, s_ar;
    logic [R_W-1:0]  m0_r, m1_r, s_r;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;
    logic            err_len;

    int n_vec = 0;
    int n_err = 0;

    axi_rd_arbiter #(.ID_W(ID_W)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar(m0_ar),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_r(m0_r),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar(m1_ar),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_r(m1_r),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
        .err_len(err_len)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic m0v, m1v, sar, srv, m0rr, m1rr, rl;
        logic e_m0ar, e_m1ar, e_sav, e_srr, e_m0rv, e_m1rv, e_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AR_W-1:0] mk_ar(input logic [31:0] addr,
                                              input logic [3:0] id,
                                              input logic [7:0] len);
        return {addr, id, len, 3'd2, 2'b01};
    endfunction

    function automatic logic [R_W-1:0] mk_r(input logic [31:0] data,
                                            input logic [1:0] resp,
                                            input logic last,
                                            input logic [3:0] id);
        return {data, resp, last, id};
    endfunction

    task automatic zero_inputs;
        m0_arvalid = 0; m0_ar = '0; m0_rready = 0;
        m1_arvalid = 0; m1_ar = '0; m1_rready = 0;
        s_arready = 0; s_rvalid = 0; s_r = '0;
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        zero_inputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_rr(input bit m, input logic v);
        if (m) m1_rready = v;
        else m0_rready = v;
    endtask

    task automatic burst(input bit m, input logic [31:0] addr,
                         input logic [7:0] len, input int nbeats,
                         input logic [1:0] resp, input int stall,
                         input bit toggle, input bit exp_err);
        logic [AR_W-1:0] p;
        logic [R_W-1:0]  r;
        int hs;
        p = mk_ar(addr, {3'b000, m}, len);
        @(negedge clock);
        if (m) begin m1_arvalid = 1; m1_ar = p; end
        else begin m0_arvalid = 1; m0_ar = p; end
        s_arready = 0;
        #1 chk("ar_latency", s_arvalid, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock); #1;
            chk("ar_stall_valid", s_arvalid, 1);
            chk("ar_stall_pay", s_ar, p);
            chk("ar_stall_rdy", m ? m1_arready : m0_arready, 0);
        end
        @(negedge clock);
        s_arready = 1;
        #1;
        chk("ar_valid", s_arvalid, 1);
        chk("ar_pay", s_ar, p);
        chk("ar_rdy_gnt", m ? m1_arready : m0_arready, 1);
        chk("ar_rdy_oth", m ? m0_arready : m1_arready, 0);
        @(negedge clock);
        if (m) m1_arvalid = 0;
        else m0_arvalid = 0;
        s_arready = 0;
        hs = 0;
        for (int i = 0; i < nbeats; i++) begin
            r = mk_r(32'hA000_0000 + i, resp, i == nbeats - 1, {3'b000, m});
            s_rvalid = 1;
            s_r = r;
            if (toggle) begin
                set_rr(m, 0);
                #1;
                chk("r_stall_valid", m ? m1_rvalid : m0_rvalid, 1);
                chk("r_stall_srdy", s_rready, 0);
                chk("r_stall_pay", m ? m1_r : m0_r, r);
                @(negedge clock);
            end
            set_rr(m, 1);
            #1;
            chk("r_valid", m ? m1_rvalid : m0_rvalid, 1);
            chk("r_pay", m ? m1_r : m0_r, r);
            chk("r_srdy", s_rready, 1);
            chk("r_oth_valid", m ? m0_rvalid : m1_rvalid, 0);
            chk("r_oth_pay", m ? m0_r : m1_r, 0);
            if ((m ? m1_rvalid : m0_rvalid) && s_rready) hs++;
            @(negedge clock);
        end
        s_rvalid = 0;
        s_r = '0;
        set_rr(m, 0);
        #1;
        chk("r_beats", hs, nbeats);
        chk("back_idle", s_arvalid, 0);
        chk("idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("err_len", err_len, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [AR_W-1:0] p0, p1;
        zero_inputs();
        #1;
        chk("rst_sav", s_arvalid, 0);
        chk("rst_rdy", {m0_arready, m1_arready, s_rready}, 0);
        chk("rst_rv", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_err", err_len, 0);

        tbl[0]  = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
        tbl[1]  = '{1,0,0,0,0,0,0, 0,0,0,0,0,0,0};
        tbl[2]  = '{1,0,0,0,0,0,0, 0,0,1,0,0,0,0};
        tbl[3]  = '{1,1,1,0,0,0,0, 1,0,1,0,0,0,0};
        tbl[4]  = '{0,1,0,1,0,0,0, 0,0,0,0,1,0,0};
        tbl[5]  = '{0,1,0,1,1,0,0, 0,0,0,1,1,0,0};
        tbl[6]  = '{0,1,0,1,1,0,1, 0,0,0,1,1,0,0};
        tbl[7]  = '{0,1,0,0,0,0,0, 0,0,0,0,0,0,0};
        tbl[8]  = '{0,1,1,0,0,0,0, 0,1,1,0,0,0,0};
        tbl[9]  = '{0,0,0,1,1,1,0, 0,0,0,1,0,1,0};
        tbl[10] = '{0,0,0,1,0,1,1, 0,0,0,1,0,1,1};
        tbl[11] = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            m0_arvalid = tbl[i].m0v;
            m1_arvalid = tbl[i].m1v;
            m0_ar      = mk_ar(32'h0000_1000, 4'd0, 8'd1);
            m1_ar      = mk_ar(32'h0000_2000, 4'd1, 8'd0);
            s_arready  = tbl[i].sar;
            s_rvalid   = tbl[i].srv;
            m0_rready  = tbl[i].m0rr;
            m1_rready  = tbl[i].m1rr;
            s_r        = mk_r(32'h1234_0000 + i, 2'b00, tbl[i].rl, 4'd0);
            #1;
            chk($sformatf("t%0d_m0ar", i), m0_arready, tbl[i].e_m0ar);
            chk($sformatf("t%0d_m1ar", i), m1_arready, tbl[i].e_m1ar);
            chk($sformatf("t%0d_sav", i), s_arvalid, tbl[i].e_sav);
            chk($sformatf("t%0d_srr", i), s_rready, tbl[i].e_srr);
            chk($sformatf("t%0d_m0rv", i), m0_rvalid, tbl[i].e_m0rv);
            chk($sformatf("t%0d_m1rv", i), m1_rvalid, tbl[i].e_m1rv);
            chk($sformatf("t%0d_err", i), err_len, tbl[i].e_err);
        end

        // single 16-beat ICache burst
        do_reset();
        burst(0, 32'h8000_0040, 8'd15, 16, 2'b00, 0, 0, 0);

        // contention from reset: strict alternation m0, m1, m0, m1
        do_reset();
        p0 = mk_ar(32'h0000_3000, 4'd0, 8'd0);
        p1 = mk_ar(32'h0000_4000, 4'd1, 8'd0);
        @(negedge clock);
        m0_arvalid = 1; m0_ar = p0; m1_arvalid = 1; m1_ar = p1;
        s_arready = 1; s_rvalid = 1; m0_rready = 1; m1_rready = 1;
        s_r = mk_r(32'hCAFE_0000, 2'b00, 1'b1, 4'd0);
        for (int b = 0; b < 4; b++) begin
            #1 chk($sformatf("c%0d_idle", b), s_arvalid, 0);
            @(negedge clock); #1;
            chk($sformatf("c%0d_m0ar", b), m0_arready, b % 2 == 0);
            chk($sformatf("c%0d_m1ar", b), m1_arready, b % 2 == 1);
            chk($sformatf("c%0d_sar", b), s_ar, (b % 2 == 1) ? p1 : p0);
            @(negedge clock); #1;
            chk($sformatf("c%0d_m0rv", b), m0_rvalid, b % 2 == 0);
            chk($sformatf("c%0d_m1rv", b), m1_rvalid, b % 2 == 1);
            @(negedge clock);
        end
        zero_inputs();
        #1 chk("c_err", err_len, 0);

        // AR stall then R backpressure
        burst(0, 32'h0000_5000, 8'd3, 4, 2'b00, 5, 1, 0);

        // short burst sets err_len, which then sticks
        burst(0, 32'h0000_6000, 8'd3, 2, 2'b00, 0, 0, 1);
        burst(1, 32'h0000_7000, 8'd1, 2, 2'b00, 0, 0, 1);

        // SLVERR on every beat is passed through
        burst(1, 32'h0000_8000, 8'd3, 4, 2'b10, 0, 0, 1);
        burst(0, 32'h0000_9000, 8'd0, 1, 2'b00, 0, 0, 1);

        // async reset mid-burst
        @(negedge clock);
        m0_arvalid = 1; m0_ar = mk_ar(32'h0000_A000, 4'd0, 8'd7);
        @(negedge clock);
        s_arready = 1;
        @(negedge clock);
        m0_arvalid = 0; s_arready = 0; s_rvalid = 1; m0_rready = 1;
        s_r = mk_r(32'h1, 2'b00, 1'b0, 4'd0);
        @(negedge clock);
        s_r = mk_r(32'h2, 2'b00, 1'b0, 4'd0);
        @(negedge clock);
        s_r = mk_r(32'h3, 2'b00, 1'b0, 4'd0);
        #1 chk("pre_rst_rv", m0_rvalid, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_rst_rv", {m0_rvalid, m1_rvalid}, 0);
        chk("ar_rst_srdy", s_rready, 0);
        chk("ar_rst_sav", s_arvalid, 0);
        chk("ar_rst_r", m0_r, 0);
        chk("ar_rst_err", err_len, 0);
        zero_inputs();
        @(negedge clock);
        reset = 1'b0;
        burst(1, 32'h0000_B000, 8'd3, 4, 2'b00, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Two-master, one-slave AXI4 read-channel arbiter. It shares the single memory read port between the instruction cache (master 0) and the LSU/data side (master 1).
- Exactly one burst is outstanding at a time.
- Grants alternate round-robin under contention.
- The R channel is routed back to the granted master until the rlast handshake.
- A beat counter checks burst length against arlen.

Parameters:
ID_W, 4, AXI ID width.
AR_W, 45+ID_W, packed AR payload width, order {araddr[31:0], arid[ID_W-1:0], arlen[7:0], arsize[2:0], arburst[1:0]}.
R_W, 35+ID_W, packed R payload width, order {rdata[31:0], rresp[1:0], rlast, rid[ID_W-1:0]}.

Ports:
clock  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
m0_arvalid  in  1  master 0 (ICache) read request valid.
m0_arready  out  1  master 0 request accepted.
m0_ar  in  AR_W  master 0 AR payload.
m0_rvalid  out  1  master 0 read data valid.
m0_rready  in  1  master 0 read data ready.
m0_r  out  R_W  master 0 R payload.
m1_arvalid / m1_arready / m1_ar / m1_rvalid / m1_rready / m1_r: same as m0, for master 1 (LSU).
s_arvalid  out  1  slave AR valid.
s_arready  in  1  slave AR ready.
s_ar  out  AR_W  slave AR payload.
s_rvalid  in  1  slave R valid.
s_rready  out  1  slave R ready.
s_r  in  R_W  slave R payload.
err_len  out  1  sticky flag for burst length mismatch.

Behaviour:
- State register: IDLE, AR, R (2 bits).
- Registers: grant (1 bit), last (1 bit, last master served), beats (8 bits), err_len.
- Async reset values: state=IDLE, grant=0, last=1 (so master 0 wins the first tie), beats=0, err_len=0.
- Reset output values: all arready/rvalid/s_arvalid/s_rready = 0.

IDLE:
- All handshake outputs are 0.
- Only m0_arvalid: grant<=0, go to AR.
- Only m1_arvalid: grant<=1, go to AR.
- Both asserted: grant<=~last, go to AR.
- Neither: stay in IDLE.

AR:
- s_arvalid=1; s_ar = payload of the granted master.
- Granted master's arready = s_arready; the other master's arready = 0.
- On s_arvalid & s_arready: beats<=0, go to R.
- Master-to-slave AR latency: 1 cycle (registered grant).
- s_arvalid never depends combinationally on s_arready.

R:
- Granted master: rvalid = s_rvalid, r = s_r.
- s_rready = granted master's rready.
- Non-granted master: rvalid=0, r=0.
- Each beat handshake: beats<=beats+1 (8-bit, wraps at 255).
- Beat with rlast=1:
  - If beats != latched arlen, set err_len.
  - last<=grant; go to IDLE.
- Beat with rlast=0 where beats == arlen: set err_len (overrun), stay in R.
- arlen is latched from s_ar at the AR handshake.

Other rules:
- R data is never buffered; it is a zero-latency pass-through.
- rresp is passed through unmodified. SLVERR/DECERR do not affect arbitration.
- A new request is granted at the earliest in the cycle after the rlast handshake; the IDLE cycle is mandatory.
- A master dropping arvalid while in AR is an AXI violation by the master. The arbiter keeps driving its payload regardless.
- A request from the non-granted master is held off (arready=0) until it is granted.
- Reset mid-burst: immediate return to IDLE with all outputs 0. The slave is reset in the same domain, so no drain is needed.
- err_len clears only on reset.

Test Plan:
- Single ICache burst: m0_arvalid with araddr=0x8000_0040, arlen=15, arburst=INCR. Required: s_arvalid 1 cycle later; 16 beats delivered on m0_r only, m1_rvalid=0 throughout; return to IDLE after rlast; err_len=0.
- Contention after reset: m0 and m1 assert in the same cycle. Required: m0 served first. With both kept requesting: m1 next, then m0 (strict alternation over 4 bursts).
- Backpressure: s_arready low 5 cycles, then m0_rready toggled 1/0 during a 4-beat burst. Required: payload stable while stalled; exactly 4 handshakes, in order, with no lost or duplicated beats.
- Length error: arlen=3, slave asserts rlast on beat 2. Required: err_len=1 from the following cycle and staying 1 through later correct bursts; FSM back in IDLE.
- Async reset in R after 2 of 8 beats. Required: all outputs 0 without waiting for a clock edge. After release, a fresh m1 request (m0 idle) completes normally.
- Error response: slave returns rresp=2'b10 on all beats of an m1 burst. Required: m1_r carries rresp=2'b10 unchanged; arbitration continues normally.
